// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the XOR cipher datapath.
// Holds the frame FSM states and the bit-serial CRC-8 step.
package xor_cipher_pkg;

  localparam int MSG_SIZE_DEF = 512;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    TRAILER
  } state_t;

  function automatic logic [7:0] crc8_bit(
    input logic [7:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ct_byte_packer_byte_fifo.sv
// Small synchronous FIFO carrying a byte plus its last tag.
// Pointers carry an extra wrap bit so full and empty differ.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       push,
  input  logic [8:0] wdata,
  input  logic       pop,
  output logic [8:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ct_byte_packer.sv
// Packs the serial ciphertext stream into bytes, appends a CRC-8
// trailer per frame and hands bytes to the host over valid/ready.
module ct_byte_packer
  import xor_cipher_pkg::*;
#(
  parameter int MSG_SIZE   = MSG_SIZE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSerial_bit,
  input  logic       iSerial_start,
  input  logic       iSerial_end,
  output logic [7:0] oByte,
  output logic       oValid,
  input  logic       iReady,
  output logic       oLast,
  output logic [$clog2(MSG_SIZE/8+1):0] oByte_count,
  output logic       oBusy,
  output logic       oOverflow,
  output logic       oFrame_err
);

  localparam int BCW = $clog2(MSG_SIZE/8+1) + 1;
  localparam int FBW = $clog2(MSG_SIZE+1);
  localparam logic [FBW-1:0] FB_MAX = FBW'(MSG_SIZE);

  state_t         state, state_n;
  logic [7:0]     shreg, sh_n, sh_set;
  logic [2:0]     bit_cnt, bcnt_n;
  logic [FBW-1:0] fbits, fbits_n;
  logic [7:0]     crc, crc_n;
  logic           pend_vld, pend_vld_n;
  logic [7:0]     pend, pend_n;
  logic [BCW-1:0] byte_cnt, cnt_n;
  logic           ovf, ovf_n;
  logic           ferr, ferr_n;
  logic           trl_push;

  logic       f_full, f_empty, f_pop, can_push;
  logic [8:0] f_rdata;

  assign f_pop    = !f_empty && iReady;
  assign can_push = !f_full || f_pop;

  always_comb begin
    state_n    = state;
    sh_n       = shreg;
    bcnt_n     = bit_cnt;
    fbits_n    = fbits;
    crc_n      = crc;
    pend_vld_n = 1'b0;
    pend_n     = pend;
    cnt_n      = byte_cnt;
    ovf_n      = ovf;
    ferr_n     = ferr;
    trl_push   = 1'b0;
    sh_set     = shreg;
    sh_set[3'd7 - bit_cnt] = iSerial_bit;

    // data bytes count even when the FIFO has no room for them
    if (pend_vld) begin
      cnt_n = byte_cnt + 1'b1;
      if (!can_push) ovf_n = 1'b1;
    end

    if (state == TRAILER) begin
      if (iSerial_start) ferr_n = 1'b1;
      if (!pend_vld && can_push) begin
        trl_push = 1'b1;
        state_n  = IDLE;
      end
    end else if (iSerial_start) begin
      if (state == RECV) ferr_n = 1'b1;
      crc_n   = crc8_bit(8'h00, iSerial_bit);
      fbits_n = FBW'(1);
      cnt_n   = '0;
      if (iSerial_end) begin
        pend_vld_n = 1'b1;
        pend_n     = {iSerial_bit, 7'b0};
        state_n    = TRAILER;
      end else begin
        sh_n    = {iSerial_bit, 7'b0};
        bcnt_n  = 3'd1;
        state_n = RECV;
      end
    end else if (state == IDLE) begin
      if (iSerial_end) ferr_n = 1'b1;
    end else if (fbits == FB_MAX) begin
      ferr_n = 1'b1;
      if (iSerial_end) begin
        pend_vld_n = (bit_cnt != 3'd0);
        pend_n     = shreg;
        state_n    = TRAILER;
      end
    end else begin
      crc_n   = crc8_bit(crc, iSerial_bit);
      fbits_n = fbits + 1'b1;
      if (iSerial_end) begin
        pend_vld_n = 1'b1;
        pend_n     = sh_set;
        state_n    = TRAILER;
      end else if (bit_cnt == 3'd7) begin
        pend_vld_n = 1'b1;
        pend_n     = sh_set;
        sh_n       = 8'h00;
        bcnt_n     = 3'd0;
      end else begin
        sh_n   = sh_set;
        bcnt_n = bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      fbits    <= '0;
      crc      <= '0;
      pend_vld <= 1'b0;
      pend     <= '0;
      byte_cnt <= '0;
      ovf      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= sh_n;
      bit_cnt  <= bcnt_n;
      fbits    <= fbits_n;
      crc      <= crc_n;
      pend_vld <= pend_vld_n;
      pend     <= pend_n;
      byte_cnt <= cnt_n;
      ovf      <= ovf_n;
      ferr     <= ferr_n;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk  (iClk),
    .iRst  (iRst),
    .push  (pend_vld || trl_push),
    .wdata (pend_vld ? {1'b0, pend} : {1'b1, crc}),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign oByte       = f_rdata[7:0];
  assign oLast       = f_rdata[8];
  assign oValid      = !f_empty;
  assign oByte_count = byte_cnt;
  assign oBusy       = (state != IDLE);
  assign oOverflow   = ovf;
  assign oFrame_err  = ferr;

endmodule
